// File: rtl/fp_add_issue_queue.sv
// rtl/fp_add_issue_queue.sv - in-order request FIFO and sequencer for a multi-cycle FP adder
// Optional: define FP_ZERO_BYPASS_EN to answer requests with a +/-0 operand without using the adder.
module fp_add_issue_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [31:0]                req_op1,
   input  logic [31:0]                req_op2,
   input  logic [TAG_W-1:0]           req_tag,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [31:0]                rsp_result,
   output logic [TAG_W-1:0]           rsp_tag,
   output logic                       fu_start,
   output logic                       fu_valid,
   output logic [31:0]                fu_op1,
   output logic [31:0]                fu_op2,
   input  logic [31:0]                fu_result,
   input  logic                       fu_done,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [2:0] {IDLE, KICK, ISSUE, WAIT, RESP} state_t;

   state_t            state_q;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              done_q;
   logic              issue_cnt_q;
   logic              fu_start_q, fu_valid_q;
   logic [31:0]       fu_op1_q, fu_op2_q;
   logic              rsp_valid_q;
   logic [31:0]       rsp_result_q;
   logic [TAG_W-1:0]  rsp_tag_q;

   logic [31:0]       mem_op1 [DEPTH];
   logic [31:0]       mem_op2 [DEPTH];
   logic [TAG_W-1:0]  mem_tag [DEPTH];

   logic              push, pop;
   logic [31:0]       head_op1, head_op2;
   logic [TAG_W-1:0]  head_tag;
   logic              bypass;
   logic [31:0]       bypass_res;

   assign req_ready  = (count_q < DEPTH_C);
   assign push       = req_valid && req_ready;
   assign pop        = rsp_valid_q && rsp_ready;
   assign head_op1   = mem_op1[rd_ptr_q];
   assign head_op2   = mem_op2[rd_ptr_q];
   assign head_tag   = mem_tag[rd_ptr_q];

`ifdef FP_ZERO_BYPASS_EN
   logic op1_zero, op2_zero;
   assign op1_zero   = (head_op1[30:0] == 31'h0);
   assign op2_zero   = (head_op2[30:0] == 31'h0);
   assign bypass     = op1_zero || op2_zero;
   assign bypass_res = (op1_zero && op2_zero) ? {head_op1[31] & head_op2[31], 31'h0} :
                       op1_zero ? head_op2 : head_op1;
`else
   assign bypass     = 1'b0;
   assign bypass_res = head_op1;
`endif

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_op1[wr_ptr_q] <= req_op1;
         mem_op2[wr_ptr_q] <= req_op2;
         mem_tag[wr_ptr_q] <= req_tag;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         done_q       <= 1'b0;
         issue_cnt_q  <= 1'b0;
         fu_start_q   <= 1'b0;
         fu_valid_q   <= 1'b0;
         fu_op1_q     <= '0;
         fu_op2_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_tag_q    <= '0;
      end else begin
         done_q     <= fu_done;
         fu_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (count_q != '0) begin
                  if (bypass) begin
                     rsp_result_q <= bypass_res;
                     rsp_tag_q    <= head_tag;
                     rsp_valid_q  <= 1'b1;
                     state_q      <= RESP;
                  end else begin
                     fu_start_q <= 1'b1;
                     fu_op1_q   <= head_op1;
                     fu_op2_q   <= head_op2;
                     state_q    <= KICK;
                  end
               end
            end
            KICK: begin
               fu_valid_q  <= 1'b1;
               issue_cnt_q <= 1'b0;
               state_q     <= ISSUE;
            end
            ISSUE: begin
               if (issue_cnt_q) begin
                  fu_valid_q <= 1'b0;
                  state_q    <= WAIT;
               end else begin
                  issue_cnt_q <= 1'b1;
               end
            end
            WAIT: begin
               // A done level left over from the previous operation is not a completion.
               if (fu_done && !done_q) begin
                  rsp_result_q <= fu_result;
                  rsp_tag_q    <= head_tag;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_tag    = rsp_tag_q;
   assign fu_start   = fu_start_q;
   assign fu_valid   = fu_valid_q;
   assign fu_op1     = fu_op1_q;
   assign fu_op2     = fu_op2_q;
   assign count      = count_q;
   assign busy       = (state_q != IDLE);

endmodule
